// File: rtl/mul_sched.sv
// Purpose: two requesters share one iterative shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH), round-robin on ties.
// Latency: result visible exactly WIDTH cycles after the acceptance edge; one product per WIDTH+2 cycles at best.
// Backpressure: a pending result holds in DONE until res_ready; no requester is granted until it drains.
//
// Ports:
//   clk, rst                   single clock; asynchronous active-high reset
//   req0_valid/a/b, req0_ready requester 0 operand pair, valid/ready handshake
//   req1_valid/a/b, req1_ready requester 1 operand pair, valid/ready handshake
//   res_valid/data/id          product and owning requester index
//   res_ready                  consumer accepts the result when high with res_valid
//   busy                       high whenever the engine is not idle
module mul_sched #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,

    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,

    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 res_id,
    input  logic                 res_ready,

    output logic                 busy
);

    // Bit counter wide enough to index every multiplier bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;      // running partial product
    logic [2*WIDTH-1:0]   mcand;    // multiplicand, shifted left one place per step
    logic [WIDTH-1:0]     mplier;   // multiplier, shifted right so bit 0 is the current bit
    logic [CW-1:0]        cnt;      // multiplier bit being processed
    logic                 last_id;  // requester served most recently

    logic                 grant;
    logic                 accept;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic [2*WIDTH-1:0]   acc_next;

    // Grant: a lone requester wins outright; on a tie the one not served last wins.
    // With no requester pending the grant still points somewhere, which keeps
    // exactly one ready high in IDLE (and zero elsewhere).
    always_comb begin
        grant = ~last_id;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && (grant == 1'b0);
    assign req1_ready = (state == IDLE) && (grant == 1'b1);

    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sel_a = grant ? req1_a : req0_a;
    assign sel_b = grant ? req1_b : req0_b;

    // The accumulator is 2*WIDTH wide and the true product never exceeds
    // 2*WIDTH bits, so no partial sum can carry out.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            last_id   <= 1'b1;      // requester 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand   <= {{WIDTH{1'b0}}, sel_a};
                        mplier  <= sel_b;
                        acc     <= '0;
                        cnt     <= '0;
                        res_id  <= grant;
                        last_id <= grant;
                        state   <= RUN;
                    end
                end

                // One multiplier bit per cycle regardless of operand values,
                // so the latency is fixed even for zero operands.
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        res_data  <= acc_next;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                // Result registers are untouched here, so they hold while stalled.
                // Leaving DONE takes the whole handshake cycle; the next grant
                // can only be taken from IDLE on the following edge.
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));

    a_valid_in_done: assert property (@(posedge clk) disable iff (rst)
        res_valid |-> (state == DONE));

    a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
        (state == DONE && !res_ready) |=> (res_valid && $stable(res_data) && $stable(res_id)));
`endif

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_id;
    logic        res_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mul_sched #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Waits (bounded) for an acceptance of requester 'which'; returns 1 ns after the acceptance edge.
    task automatic do_accept(input bit which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((which == 1'b0 && req0_valid && req0_ready) ||
                (which == 1'b1 && req1_valid && req1_ready)) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called 1 ns after the acceptance edge; lat = edges until res_valid seen, -1 on timeout.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL rst_res_data: got %0d expected 0", res_data); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL rst_res_id: got %b expected 0", res_id); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_req0_ready: got %b expected 1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready: got %b expected 0", req1_ready); end
        // A valid request during reset must not be accepted.
        req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd4;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_accept_busy: got %b expected 0", busy); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_req0_ready: got %b expected 1", req0_ready); end
        req0_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got busy=%b res_valid=%b expected 0 0", busy, res_valid); end
    endtask

    task automatic test_single();
        bit ok; int lat;
        res_ready = 1'b1;
        req0_a = 16'd123; req0_b = 16'd345; req0_valid = 1'b1;
        do_accept(1'b0, ok);
        req0_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL single_latency: got %0d expected 16", lat); end
        checks++; if (res_data !== 32'd42435) begin errors++; $display("FAIL single_data: got %0d expected 42435", res_data); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", res_id); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_handshake: got res_valid=%b busy=%b expected 0 0", res_valid, busy); end
    endtask

    task automatic test_tie();
        bit ok; int lat;
        rst = 1'b1;
        res_ready = 1'b1;
        req0_a = 16'd154; req0_b = 16'd654; req0_valid = 1'b1;
        req1_a = 16'd186; req1_b = 16'd348; req1_valid = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie1_grant: got ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready); end
        do_accept(1'b0, ok);
        req0_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL tie1_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL tie1_latency: got %0d expected 16", lat); end
        checks++; if (res_data !== 32'd100716 || res_id !== 1'b0) begin errors++; $display("FAIL tie1_result: got %0d id %b expected 100716 id 0", res_data, res_id); end
        do_accept(1'b1, ok);
        req1_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL tie2_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL tie2_latency: got %0d expected 16", lat); end
        checks++; if (res_data !== 32'd64728 || res_id !== 1'b1) begin errors++; $display("FAIL tie2_result: got %0d id %b expected 64728 id 1", res_data, res_id); end
        // Second tie after requester 1 was served: requester 0 must win.
        req0_a = 16'd7; req0_b = 16'd9; req0_valid = 1'b1;
        req1_a = 16'd5; req1_b = 16'd5; req1_valid = 1'b1;
        @(posedge clk); #2;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie3_grant: got ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready); end
        do_accept(1'b0, ok);
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL tie3_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (res_data !== 32'd63 || res_id !== 1'b0) begin errors++; $display("FAIL tie3_result: got %0d id %b expected 63 id 0", res_data, res_id); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL tie_handshake: got %b expected 0", res_valid); end
    endtask

    task automatic test_extremes();
        bit ok; int lat;
        res_ready = 1'b1;
        req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_valid = 1'b1;
        do_accept(1'b1, ok);
        req1_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL max_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL max_latency: got %0d expected 16", lat); end
        checks++; if (res_data !== 32'd4294836225 || res_id !== 1'b1) begin errors++; $display("FAIL max_result: got %0d id %b expected 4294836225 id 1", res_data, res_id); end
        req0_a = 16'd0; req0_b = 16'hFFFF; req0_valid = 1'b1;
        do_accept(1'b0, ok);
        req0_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL zero_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL zero_latency: got %0d expected 16", lat); end
        checks++; if (res_data !== 32'd0 || res_id !== 1'b0) begin errors++; $display("FAIL zero_result: got %0d id %b expected 0 id 0", res_data, res_id); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL extremes_handshake: got %b expected 0", res_valid); end
    endtask

    task automatic test_stall();
        bit ok; int lat;
        res_ready = 1'b0;
        req0_a = 16'd1000; req0_b = 16'd1000; req0_valid = 1'b1;
        do_accept(1'b0, ok);
        req0_valid = 1'b0;
        // Operand changes during the run must not disturb the product.
        req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        checks++; if (!ok) begin errors++; $display("FAIL stall_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL stall_latency: got %0d expected 16", lat); end
        req1_a = 16'd2; req1_b = 16'd2; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, res_valid); end
            checks++; if (res_data !== 32'd1000000 || res_id !== 1'b0) begin errors++; $display("FAIL stall_result[%0d]: got %0d id %b expected 1000000 id 0", i, res_data, res_id); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %b expected 1", i, busy); end
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b %b expected 0 0", i, req0_ready, req1_ready); end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        // Handshake edge: back to IDLE with no acceptance in the same cycle.
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_release: got res_valid=%b busy=%b expected 0 0", res_valid, busy); end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok; int lat;
        res_ready = 1'b1;
        req0_a = 16'd500; req0_b = 16'd3; req0_valid = 1'b1;
        do_accept(1'b0, ok);
        req0_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL midrst_accept: got timeout expected acceptance"); end
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async: got res_valid=%b busy=%b expected 0 0", res_valid, busy); end
        checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL midrst_data: got %0d expected 0", res_data); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_abandon: got res_valid=%b busy=%b expected 0 0", res_valid, busy); end
        req1_a = 16'd186; req1_b = 16'd348; req1_valid = 1'b1;
        do_accept(1'b1, ok);
        req1_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL midrst_next_accept: got timeout expected acceptance"); end
        wait_result(lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL midrst_latency: got %0d expected 16", lat); end
        checks++; if (res_data !== 32'd64728 || res_id !== 1'b1) begin errors++; $display("FAIL midrst_result: got %0d id %b expected 64728 id 1", res_data, res_id); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_handshake: got %b expected 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; int t_acc; int t_prev;
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [31:0] vp [3];
        va[0] = 16'd2;     vb[0] = 16'd3;     vp[0] = 32'd6;
        va[1] = 16'd40000; vb[1] = 16'd50000; vp[1] = 32'd2000000000;
        va[2] = 16'd65535; vb[2] = 16'd1;     vp[2] = 32'd65535;
        res_ready = 1'b1;
        t_prev = 0;
        req0_a = va[0]; req0_b = vb[0]; req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_accept(1'b0, ok);
            t_acc = cyc;
            if (i < 2) begin
                req0_a = va[i+1]; req0_b = vb[i+1];
            end else begin
                req0_valid = 1'b0;
            end
            checks++; if (!ok) begin errors++; $display("FAIL b2b_accept[%0d]: got timeout expected acceptance", i); end
            if (i > 0) begin
                checks++; if (t_acc - t_prev != 18) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 18", i, t_acc - t_prev); end
            end
            wait_result(lat);
            checks++; if (lat != 16) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 16", i, lat); end
            checks++; if (res_data !== vp[i] || res_id !== 1'b0) begin errors++; $display("FAIL b2b_result[%0d]: got %0d id %b expected %0d id 0", i, res_data, res_id, vp[i]); end
            t_prev = t_acc;
        end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: got res_valid=%b busy=%b expected 0 0", res_valid, busy); end
    endtask

    initial begin
        req0_valid = 1'b0; req0_a = 16'd0; req0_b = 16'd0;
        req1_valid = 1'b0; req1_a = 16'd0; req1_b = 16'd0;
        res_ready  = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_extremes();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
